// File: rtl/expr_pkg.sv
// Shared constants and encodings for the expression evaluator.
// Character classes and FSM states used by expr_eval.
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    typedef enum logic [1:0] {
        EXP_DIGIT,
        EXP_OP,
        ERROR
    } state_e;

    typedef enum logic [2:0] {
        CL_DIGIT,
        CL_ADD,
        CL_MUL,
        CL_EQ,
        CL_ILLEGAL
    } cls_e;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier.
// Splits a byte into a character class and a digit value.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch,
    output cls_e       cls,
    output logic [3:0] dval
);

    logic [7:0] diff;

    assign diff = ch - CH_0;

    always_comb begin
        cls  = CL_ILLEGAL;
        dval = 4'd0;
        unique case (1'b1)
            (ch >= CH_0 && ch <= CH_9): begin
                cls  = CL_DIGIT;
                dval = diff[3:0];
            end
            (ch == CH_ADD): cls = CL_ADD;
            (ch == CH_MUL): cls = CL_MUL;
            (ch == CH_EQ):  cls = CL_EQ;
            default:        cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/expr_eval.sv
// Single-digit '+'/'*' expression evaluator with precedence.
// Emits a result pulse on '=' or an error pulse for malformed input.
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic [W-1:0] result,
    output logic         res_valid,
    output logic         ovf,
    output logic         err
);

    cls_e           cls;
    logic [3:0]     dval;
    state_e         state;
    logic [W-1:0]   sum;
    logic [W-1:0]   prod;
    logic           mul_pend;
    logic           ovf_acc;
    logic [W:0]     sum_add;
    logic [2*W-1:0] mul_full;

    expr_char_class u_cls (
        .ch   (in),
        .cls  (cls),
        .dval (dval)
    );

    // Carry and high product half feed the overflow flag.
    assign sum_add  = {1'b0, sum} + {1'b0, prod};
    assign mul_full = {{W{1'b0}}, prod} * {{(2*W-4){1'b0}}, dval};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= EXP_DIGIT;
            sum       <= '0;
            prod      <= '0;
            mul_pend  <= 1'b0;
            ovf_acc   <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid) begin
                case (state)
                    EXP_DIGIT: begin
                        case (cls)
                            CL_DIGIT: begin
                                if (mul_pend) begin
                                    prod     <= mul_full[W-1:0];
                                    mul_pend <= 1'b0;
                                    if (|mul_full[2*W-1:W])
                                        ovf_acc <= 1'b1;
                                end else begin
                                    prod <= {{(W-4){1'b0}}, dval};
                                end
                                state <= EXP_OP;
                            end
                            CL_EQ: begin
                                err      <= 1'b1;
                                sum      <= '0;
                                prod     <= '0;
                                mul_pend <= 1'b0;
                                ovf_acc  <= 1'b0;
                                state    <= EXP_DIGIT;
                            end
                            default: state <= ERROR;
                        endcase
                    end
                    EXP_OP: begin
                        case (cls)
                            CL_ADD: begin
                                sum  <= sum_add[W-1:0];
                                prod <= '0;
                                if (sum_add[W])
                                    ovf_acc <= 1'b1;
                                state <= EXP_DIGIT;
                            end
                            CL_MUL: begin
                                mul_pend <= 1'b1;
                                state    <= EXP_DIGIT;
                            end
                            CL_EQ: begin
                                result    <= sum_add[W-1:0];
                                ovf       <= ovf_acc | sum_add[W];
                                res_valid <= 1'b1;
                                sum       <= '0;
                                prod      <= '0;
                                mul_pend  <= 1'b0;
                                ovf_acc   <= 1'b0;
                                state     <= EXP_DIGIT;
                            end
                            default: state <= ERROR;
                        endcase
                    end
                    default: begin
                        if (cls == CL_EQ) begin
                            err      <= 1'b1;
                            sum      <= '0;
                            prod     <= '0;
                            mul_pend <= 1'b0;
                            ovf_acc  <= 1'b0;
                            state    <= EXP_DIGIT;
                        end
                    end
                endcase
            end
        end
    end

endmodule
